calc_driver: RTL and testbench

- Initiator (requester) side of the CALC go/done operand handshake.
- Sweeps every {op, in1, in2} combination, 4 x 8 x 8 = 256 vectors, into a CALC instance.
- Compares each returned result against an internal golden model.
- Reports pass/fail, error count, first failing vector and handshake timeouts.
- Used as an on-chip built-in self-test front end, replacing the simulation-only bench.

---
 rtl/calc_pkg.sv | 21 ++
 rtl/calc_golden.sv | 25 ++
 rtl/calc_driver.sv | 178 +++++++++++++++++
 tb/tb_calc_driver.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the CALC block and its built-in self-test driver:
// opcode constants and the driver's state encoding.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_REQ,
    ST_CHECK,
    ST_RELEASE,
    ST_NEXT,
    ST_FINISH,
    ST_TOUT
  } drv_state_e;

endpackage

// File: rtl/calc_golden.sv
// Combinational W-bit reference ALU matching CALC's opcode set; all results
// wrap modulo 2^W.
module calc_golden
  import calc_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/calc_driver.sv
// Built-in self-test initiator for CALC: sweeps every {op,in1,in2} vector over
// a four-phase go/done handshake and checks each result against calc_golden.
module calc_driver
  import calc_pkg::*;
#(
  parameter int W            = 3,
  parameter int TIMEOUT      = 15,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic [W-1:0]   calc_in1,
  output logic [W-1:0]   calc_in2,
  output logic [1:0]     calc_op,
  output logic           calc_go,
  input  logic [W-1:0]   calc_out,
  input  logic           calc_done,
  output logic           busy,
  output logic           finished,
  output logic           fail,
  output logic           timeout,
  output logic [2*W+2:0] err_count,
  output logic [1:0]     fail_op,
  output logic [W-1:0]   fail_in1,
  output logic [W-1:0]   fail_in2,
  output logic [W-1:0]   fail_out
);

  localparam int IW = 2*W + 2;
  localparam int EW = 2*W + 3;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT);

  drv_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] timer_inc;
  logic          tmo;
  logic [EW-1:0] err_q, err_d;
  logic          fail_q, fail_d;
  logic [1:0]    fop_q, fop_d;
  logic [W-1:0]  fin1_q, fin1_d;
  logic [W-1:0]  fin2_q, fin2_d;
  logic [W-1:0]  fout_q, fout_d;
  logic [W-1:0]  res_q, res_d;
  logic [W-1:0]  gold_y;

  function automatic logic [EW-1:0] sat_inc(input logic [EW-1:0] v);
    return (&v) ? v : v + EW'(1);
  endfunction

  assign calc_op  = idx_q[IW-1 -: 2];
  assign calc_in1 = idx_q[2*W-1 -: W];
  assign calc_in2 = idx_q[W-1:0];

  calc_golden #(.W(W)) u_golden (
    .op (calc_op),
    .a  (calc_in1),
    .b  (calc_in2),
    .y  (gold_y)
  );

  // Timeout fires on the edge where the count would reach TIMEOUT.
  assign timer_inc = timer_q + TW'(1);
  assign tmo       = (timer_inc == TO_VAL);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    err_d   = err_q;
    fail_d  = fail_q;
    fop_d   = fop_q;
    fin1_d  = fin1_q;
    fin2_d  = fin2_q;
    fout_d  = fout_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE, ST_FINISH, ST_TOUT: begin
        if (start) begin
          state_d = ST_SETUP;
          idx_d   = '0;
          err_d   = '0;
          fail_d  = 1'b0;
          fop_d   = '0;
          fin1_d  = '0;
          fin2_d  = '0;
          fout_d  = '0;
        end
      end
      ST_SETUP: begin
        timer_d = timer_inc;
        if (!calc_done)  state_d = ST_REQ;
        else if (tmo)    state_d = ST_TOUT;
      end
      ST_REQ: begin
        timer_d = timer_inc;
        if (calc_done) begin
          state_d = ST_CHECK;
          res_d   = calc_out;
        end else if (tmo) begin
          state_d = ST_TOUT;
        end
      end
      ST_CHECK: begin
        state_d = ST_RELEASE;
        if (res_q != gold_y) begin
          err_d  = sat_inc(err_q);
          fail_d = 1'b1;
          if (!fail_q) begin
            fop_d  = calc_op;
            fin1_d = calc_in1;
            fin2_d = calc_in2;
            fout_d = res_q;
          end
        end
      end
      ST_RELEASE: begin
        timer_d = timer_inc;
        if (!calc_done)  state_d = (fail_q && STOP_ON_FAIL) ? ST_FINISH : ST_NEXT;
        else if (tmo)    state_d = ST_TOUT;
      end
      ST_NEXT: begin
        if (&idx_q) begin
          state_d = ST_FINISH;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ST_SETUP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      err_q   <= '0;
      fail_q  <= 1'b0;
      fop_q   <= '0;
      fin1_q  <= '0;
      fin2_q  <= '0;
      fout_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      fop_q   <= fop_d;
      fin1_q  <= fin1_d;
      fin2_q  <= fin2_d;
      fout_q  <= fout_d;
    end
  end

  // Captured result is pure data, only read in CHECK after being loaded.
  always_ff @(posedge clk) begin
    res_q <= res_d;
  end

  assign calc_go   = (state_q == ST_REQ);
  assign busy      = (state_q == ST_SETUP) || (state_q == ST_REQ) || (state_q == ST_CHECK) ||
                     (state_q == ST_RELEASE) || (state_q == ST_NEXT);
  assign finished  = (state_q == ST_FINISH) || (state_q == ST_TOUT);
  assign timeout   = (state_q == ST_TOUT);
  assign fail      = fail_q;
  assign err_count = err_q;
  assign fail_op   = fop_q;
  assign fail_in1  = fin1_q;
  assign fail_in2  = fin2_q;
  assign fail_out  = fout_q;

endmodule

// File: tb/tb_calc_driver.sv
// Directed bench for calc_driver: behavioural CALC responders with injectable
// faults, go-order monitors, and immediate-assertion checks.
module tb_calc_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic [2:0] calc_in1, calc_in2, calc_out;
  logic [1:0] calc_op;
  logic       calc_go, calc_done;
  logic       busy, finished, fail, timeout;
  logic [8:0] err_count;
  logic [1:0] fail_op;
  logic [2:0] fail_in1, fail_in2, fail_out;

  logic [2:0] c2_in1, c2_in2, c2_out;
  logic [1:0] c2_op;
  logic       c2_go, c2_done;
  logic       busy2, finished2, fail2, timeout2;
  logic [8:0] err_count2;
  logic [1:0] fail_op2;
  logic [2:0] fail_in1_2, fail_in2_2, fail_out_2;

  int checks = 0;
  int errors = 0;
  int mode = 0;
  logic force_done = 1'b0;

  always #5 clk = ~clk;

  calc_driver dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .calc_in1(calc_in1), .calc_in2(calc_in2), .calc_op(calc_op), .calc_go(calc_go),
    .calc_out(calc_out), .calc_done(calc_done),
    .busy(busy), .finished(finished), .fail(fail), .timeout(timeout),
    .err_count(err_count), .fail_op(fail_op), .fail_in1(fail_in1),
    .fail_in2(fail_in2), .fail_out(fail_out)
  );

  calc_driver #(.W(3), .TIMEOUT(15), .STOP_ON_FAIL(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .calc_in1(c2_in1), .calc_in2(c2_in2), .calc_op(c2_op), .calc_go(c2_go),
    .calc_out(c2_out), .calc_done(c2_done),
    .busy(busy2), .finished(finished2), .fail(fail2), .timeout(timeout2),
    .err_count(err_count2), .fail_op(fail_op2), .fail_in1(fail_in1_2),
    .fail_in2(fail_in2_2), .fail_out(fail_out_2)
  );

  // Mode 1: add 3+5 returns 7. Mode 2: xor returns 0. Mode 3: no done from vector 10.
  function automatic logic [2:0] model_res(input int md, input logic [1:0] op,
                                           input logic [2:0] a, input logic [2:0] b);
    logic [2:0] r;
    case (op)
      2'b00:   r = a + b;
      2'b01:   r = a - b;
      2'b10:   r = a & b;
      default: r = a ^ b;
    endcase
    if (md == 1 && op == 2'b00 && a == 3'd3 && b == 3'd5) r = 3'd7;
    if (md == 2 && op == 2'b11) r = 3'd0;
    return r;
  endfunction

  // CALC model: done rises two cycles after go, falls one cycle after go drops.
  logic       m_done = 1'b0, m2_done = 1'b0;
  logic [1:0] m_cnt = 2'd0, m2_cnt = 2'd0;
  logic [2:0] m_out = 3'd0, m2_out = 3'd0;

  always @(posedge clk) begin
    if (!calc_go) begin
      m_cnt  <= 2'd0;
      m_done <= 1'b0;
    end else if (!m_done && !(mode == 3 && {calc_op, calc_in1, calc_in2} >= 8'd10)) begin
      if (m_cnt == 2'd1) begin
        m_done <= 1'b1;
        m_out  <= model_res(mode, calc_op, calc_in1, calc_in2);
      end else begin
        m_cnt <= m_cnt + 2'd1;
      end
    end
  end
  assign calc_done = m_done | force_done;
  assign calc_out  = m_out;

  always @(posedge clk) begin
    if (!c2_go) begin
      m2_cnt  <= 2'd0;
      m2_done <= 1'b0;
    end else if (!m2_done) begin
      if (m2_cnt == 2'd1) begin
        m2_done <= 1'b1;
        m2_out  <= model_res(2, c2_op, c2_in1, c2_in2);
      end else begin
        m2_cnt <= m2_cnt + 2'd1;
      end
    end
  end
  assign c2_done = m2_done;
  assign c2_out  = m2_out;

  // Go monitors: count go pulses since the last accepted start and check order.
  logic [7:0] exp_idx = 8'd0, exp_idx2 = 8'd0;
  logic       go_prev = 1'b0, go_prev2 = 1'b0;
  int go_cnt = 0, order_err = 0, go_cnt2 = 0, order_err2 = 0;

  always @(posedge clk) begin
    go_prev <= calc_go;
    if (start && !busy) begin
      exp_idx <= 8'd0;
      go_cnt  <= 0;
    end else if (calc_go && !go_prev) begin
      if ({calc_op, calc_in1, calc_in2} != exp_idx) order_err <= order_err + 1;
      exp_idx <= exp_idx + 8'd1;
      go_cnt  <= go_cnt + 1;
    end
  end

  always @(posedge clk) begin
    go_prev2 <= c2_go;
    if (start2 && !busy2) begin
      exp_idx2 <= 8'd0;
      go_cnt2  <= 0;
    end else if (c2_go && !go_prev2) begin
      if ({c2_op, c2_in1, c2_in2} != exp_idx2) order_err2 <= order_err2 + 1;
      exp_idx2 <= exp_idx2 + 8'd1;
      go_cnt2  <= go_cnt2 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_fin(input int limit);
    int n = 0;
    while (!finished && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_go(input logic [7:0] target, input int limit);
    int n = 0;
    while (!(calc_go && {calc_op, calc_in1, calc_in2} == target) && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_go", 32'(calc_go), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_finished", 32'(finished), 0);
    chk("rst_vec", 32'({calc_op, calc_in1, calc_in2}), 0);
    chk("rst_err", 32'(err_count), 0);
    rst_n = 1'b1;
    step(2);

    // Correct sweep, with a start pulse while busy that must be ignored
    mode = 0;
    pulse_start();
    chk("busy_after_start", 32'(busy), 1);
    wait_go(8'd40, 1000);
    chk("reach_vec40", 32'(calc_go), 1);
    pulse_start();
    chk("start_ignored_vec", 32'({calc_op, calc_in1, calc_in2}), 40);
    chk("start_ignored_busy", 32'(busy), 1);
    wait_fin(3000);
    chk("ok_finished", 32'(finished), 1);
    chk("ok_busy", 32'(busy), 0);
    chk("ok_fail", 32'(fail), 0);
    chk("ok_err", 32'(err_count), 0);
    chk("ok_timeout", 32'(timeout), 0);
    chk("ok_go_count", 32'(go_cnt), 256);
    chk("ok_order", 32'(order_err), 0);

    // Bad add 3+5 with stop-on-fail
    mode = 1;
    pulse_start();
    wait_fin(3000);
    chk("sof_finished", 32'(finished), 1);
    chk("sof_fail", 32'(fail), 1);
    chk("sof_err", 32'(err_count), 1);
    chk("sof_fail_op", 32'(fail_op), 0);
    chk("sof_fail_in1", 32'(fail_in1), 3);
    chk("sof_fail_in2", 32'(fail_in2), 5);
    chk("sof_fail_out", 32'(fail_out), 7);
    step(20);
    chk("sof_go_count", 32'(go_cnt), 30);
    chk("sof_timeout", 32'(timeout), 0);

    // XOR returns 0, full sweep without stopping
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    begin
      int n = 0;
      while (!finished2 && n < 3000) begin
        @(negedge clk);
        n++;
      end
    end
    chk("nsf_finished", 32'(finished2), 1);
    chk("nsf_err", 32'(err_count2), 56);
    chk("nsf_fail", 32'(fail2), 1);
    chk("nsf_fail_op", 32'(fail_op2), 3);
    chk("nsf_fail_in1", 32'(fail_in1_2), 0);
    chk("nsf_fail_in2", 32'(fail_in2_2), 1);
    chk("nsf_fail_out", 32'(fail_out_2), 0);
    chk("nsf_go_count", 32'(go_cnt2), 256);
    chk("nsf_order", 32'(order_err2), 0);

    // No done from vector 10: timeout exactly 15 cycles after go rises
    mode = 3;
    pulse_start();
    wait_go(8'd10, 200);
    chk("to_go_rise", 32'(calc_go), 1);
    step(14);
    chk("to_go_held", 32'(calc_go), 1);
    chk("to_not_yet", 32'(timeout), 0);
    step(1);
    chk("to_go_drop", 32'(calc_go), 0);
    chk("to_timeout", 32'(timeout), 1);
    chk("to_finished", 32'(finished), 1);
    chk("to_busy", 32'(busy), 0);
    chk("to_vec", 32'({calc_op, calc_in1, calc_in2}), 10);
    step(5);
    chk("to_sticky", 32'(timeout), 1);
    mode = 0;
    pulse_start();
    chk("restart_vec", 32'({calc_op, calc_in1, calc_in2}), 0);
    chk("restart_timeout", 32'(timeout), 0);
    chk("restart_finished", 32'(finished), 0);
    wait_fin(3000);
    chk("restart_go_count", 32'(go_cnt), 256);
    chk("restart_order", 32'(order_err), 0);

    // Asynchronous reset during vector 100
    pulse_start();
    wait_go(8'd100, 1000);
    chk("rv_go", 32'(calc_go), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rv_go_low", 32'(calc_go), 0);
    chk("rv_busy_low", 32'(busy), 0);
    chk("rv_finished_low", 32'(finished), 0);
    chk("rv_vec_low", 32'({calc_op, calc_in1, calc_in2}), 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    pulse_start();
    chk("rv_first_vec", 32'({calc_op, calc_in1, calc_in2}), 0);
    wait_go(8'd0, 20);
    chk("rv_first_go", 32'(calc_go), 1);
    wait_fin(3000);
    chk("rv_go_count", 32'(go_cnt), 256);
    chk("rv_order", 32'(order_err), 0);

    // done stuck high before the first go
    force_done = 1'b1;
    pulse_start();
    chk("stuck_busy", 32'(busy), 1);
    chk("stuck_go", 32'(calc_go), 0);
    step(14);
    chk("stuck_go_late", 32'(calc_go), 0);
    chk("stuck_not_yet", 32'(timeout), 0);
    step(1);
    chk("stuck_timeout", 32'(timeout), 1);
    chk("stuck_finished", 32'(finished), 1);
    chk("stuck_busy_end", 32'(busy), 0);
    chk("stuck_go_count", 32'(go_cnt), 0);
    force_done = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
